// File: rtl/exc_sequencer.sv
// Exception/interrupt/ERET commit sequencer between MEM and COP0.
// Ports: MEM-stage instruction + exception flags and COP0 status in;
//   COP0 exception-update bundle, flush, PC redirect and busy out.
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic        inst_bd,
  input  logic        exc_fetch_adel,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_syscall,
  input  logic        exc_break,
  input  logic        exc_load_adel,
  input  logic        exc_store_ades,
  input  logic [31:0] mem_addr,
  input  logic        inst_eret,
  input  logic        mem_stall,
  input  logic        allow_interrupt,
  input  logic [7:0]  interrupt_flag,
  input  logic [31:0] epc_address,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic [31:0] exp_badvaddr,
  output logic        exp_bd,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exl_clean,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_FLUSH
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] target;
  logic [4:0]  last_code;
  logic        last_bd;

  logic        irq;
  logic        hit;
  logic        is_exc;
  logic [4:0]  code;
  logic        bva_en;
  logic [31:0] bva;
  logic [31:0] epc_exc;

  always_comb begin
    irq     = allow_interrupt & (|interrupt_flag);
    hit     = 1'b1;
    is_exc  = 1'b1;
    code    = 5'd0;
    bva_en  = 1'b0;
    bva     = 32'd0;
    epc_exc = inst_bd ? inst_pc - 32'd4 : inst_pc;
    priority case (1'b1)
      irq: code = 5'd0;
      exc_fetch_adel: begin
        code   = 5'd4;
        bva_en = 1'b1;
        bva    = inst_pc;
      end
      exc_ri:      code = 5'd10;
      exc_ov:      code = 5'd12;
      exc_syscall: code = 5'd8;
      exc_break:   code = 5'd9;
      exc_load_adel: begin
        code   = 5'd4;
        bva_en = 1'b1;
        bva    = mem_addr;
      end
      exc_store_ades: begin
        code   = 5'd5;
        bva_en = 1'b1;
        bva    = mem_addr;
      end
      inst_eret: is_exc = 1'b0;
      default: begin
        hit    = 1'b0;
        is_exc = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      cnt             <= 4'd0;
      target          <= 32'd0;
      last_code       <= 5'd0;
      last_bd         <= 1'b0;
      exp_en          <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      exp_badvaddr    <= 32'd0;
      exp_bd          <= 1'b0;
      exp_code        <= 5'd0;
      exp_epc         <= 32'd0;
      exl_clean       <= 1'b0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= 32'd0;
      busy            <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      unique case (state)
        S_IDLE: begin
          if (inst_valid && hit) begin
            state  <= S_COMMIT;
            exp_en <= 1'b1;
            flush  <= 1'b1;
            busy   <= 1'b1;
            if (is_exc) begin
              exp_badvaddr_en <= bva_en;
              exp_badvaddr    <= bva;
              exp_bd          <= inst_bd;
              exp_code        <= code;
              exp_epc         <= epc_exc;
              exl_clean       <= 1'b0;
              target          <= EXC_VECTOR;
              last_code       <= code;
              last_bd         <= inst_bd;
            end else begin
              // ERET rewrites Cause/EPC with their current values
              exp_badvaddr_en <= 1'b0;
              exp_badvaddr    <= 32'd0;
              exp_bd          <= last_bd;
              exp_code        <= last_code;
              exp_epc         <= epc_address;
              exl_clean       <= 1'b1;
              target          <= epc_address;
            end
          end
        end
        S_COMMIT: begin
          if (!mem_stall) begin
            state  <= S_FLUSH;
            exp_en <= 1'b0;
            cnt    <= CNT_INIT;
            if (CNT_INIT == 4'd0) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= target;
            end
          end
        end
        S_FLUSH: begin
          if (cnt == 4'd0) begin
            state <= S_IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
            // pulse lines up with the cycle the counter reads zero
            if (cnt == 4'd1) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= target;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer.
// Directed scenarios then randomized events against a reference model.
module tb_exc_sequencer;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        inst_bd;
  logic        exc_fetch_adel;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_syscall;
  logic        exc_break;
  logic        exc_load_adel;
  logic        exc_store_ades;
  logic [31:0] mem_addr;
  logic        inst_eret;
  logic        mem_stall;
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic [31:0] epc_address;
  logic        exp_en;
  logic        exp_badvaddr_en;
  logic [31:0] exp_badvaddr;
  logic        exp_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exl_clean;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  exc_sequencer #(
    .EXC_VECTOR  (VEC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_bd        (inst_bd),
    .exc_fetch_adel (exc_fetch_adel),
    .exc_ri         (exc_ri),
    .exc_ov         (exc_ov),
    .exc_syscall    (exc_syscall),
    .exc_break      (exc_break),
    .exc_load_adel  (exc_load_adel),
    .exc_store_ades (exc_store_ades),
    .mem_addr       (mem_addr),
    .inst_eret      (inst_eret),
    .mem_stall      (mem_stall),
    .allow_interrupt(allow_interrupt),
    .interrupt_flag (interrupt_flag),
    .epc_address    (epc_address),
    .exp_en         (exp_en),
    .exp_badvaddr_en(exp_badvaddr_en),
    .exp_badvaddr   (exp_badvaddr),
    .exp_bd         (exp_bd),
    .exp_code       (exp_code),
    .exp_epc        (exp_epc),
    .exl_clean      (exl_clean),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        fa;
    logic        ri;
    logic        ov;
    logic        sys;
    logic        bp;
    logic        la;
    logic        sa;
    logic [31:0] addr;
    logic        eret;
    logic        ai;
    logic [7:0]  irq;
    logic [31:0] epc;
  } ev_t;

  typedef struct packed {
    logic        hit;
    logic [4:0]  code;
    logic        bva_en;
    logic [31:0] bva;
    logic        bd;
    logic [31:0] epc;
    logic        exl;
    logic [31:0] target;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] m_last_code = 5'd0;
  logic       m_last_bd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ev_t quiet_ev();
    ev_t e;
    e = '0;
    return e;
  endfunction

  function automatic ev_t rand_ev();
    ev_t e;
    e       = '0;
    e.valid = ($urandom % 8) != 0;
    e.pc    = $urandom;
    e.bd    = 1'($urandom % 2);
    e.fa    = ($urandom % 10) == 0;
    e.ri    = ($urandom % 10) == 0;
    e.ov    = ($urandom % 10) == 0;
    e.sys   = ($urandom % 10) == 0;
    e.bp    = ($urandom % 10) == 0;
    e.la    = ($urandom % 10) == 0;
    e.sa    = ($urandom % 10) == 0;
    e.addr  = $urandom;
    e.eret  = ($urandom % 3) == 0;
    e.ai    = 1'($urandom % 2);
    e.irq   = (($urandom % 4) == 0) ? 8'($urandom) : 8'd0;
    e.epc   = $urandom;
    return e;
  endfunction

  function automatic ev_t junk_ev();
    ev_t e;
    e       = rand_ev();
    e.valid = 1'b1;
    e.bp    = 1'b1;
    return e;
  endfunction

  task automatic drive(input ev_t e);
    inst_valid      = e.valid;
    inst_pc         = e.pc;
    inst_bd         = e.bd;
    exc_fetch_adel  = e.fa;
    exc_ri          = e.ri;
    exc_ov          = e.ov;
    exc_syscall     = e.sys;
    exc_break       = e.bp;
    exc_load_adel   = e.la;
    exc_store_ades  = e.sa;
    mem_addr        = e.addr;
    inst_eret       = e.eret;
    allow_interrupt = e.ai;
    interrupt_flag  = e.irq;
    epc_address     = e.epc;
  endtask

  // Cause/EPC/BadVAddr/target implied by the architectural rules.
  function automatic exp_t model(input ev_t e);
    exp_t x;
    x = '0;
    if (!e.valid) return x;
    x.hit    = 1'b1;
    x.target = VEC;
    x.bd     = e.bd;
    x.epc    = e.bd ? e.pc - 32'd4 : e.pc;
    if (e.ai && e.irq != 8'd0) x.code = 5'd0;
    else if (e.fa) begin
      x.code = 5'd4; x.bva_en = 1'b1; x.bva = e.pc;
    end
    else if (e.ri)  x.code = 5'd10;
    else if (e.ov)  x.code = 5'd12;
    else if (e.sys) x.code = 5'd8;
    else if (e.bp)  x.code = 5'd9;
    else if (e.la) begin
      x.code = 5'd4; x.bva_en = 1'b1; x.bva = e.addr;
    end
    else if (e.sa) begin
      x.code = 5'd5; x.bva_en = 1'b1; x.bva = e.addr;
    end
    else if (e.eret) begin
      x.exl    = 1'b1;
      x.code   = m_last_code;
      x.bd     = m_last_bd;
      x.epc    = e.epc;
      x.target = e.epc;
    end
    else x.hit = 1'b0;
    return x;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},    32'(exp_en), 0);
    chk({tag, "_bvaen"}, 32'(exp_badvaddr_en), 0);
    chk({tag, "_bva"},   exp_badvaddr, 0);
    chk({tag, "_bd"},    32'(exp_bd), 0);
    chk({tag, "_code"},  32'(exp_code), 0);
    chk({tag, "_epc"},   exp_epc, 0);
    chk({tag, "_exl"},   32'(exl_clean), 0);
    chk({tag, "_flush"}, 32'(flush), 0);
    chk({tag, "_rv"},    32'(redirect_valid), 0);
    chk({tag, "_rpc"},   redirect_pc, 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  // Entered and left at posedge+1 of an idle cycle.
  task automatic step(input string tag, input ev_t e, input int stall_n);
    exp_t x;
    x = model(e);
    drive(e);
    mem_stall = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_flush"}, 32'(flush), 0);
    chk({tag, "_idle_rv"}, 32'(redirect_valid), 0);
    @(posedge clk); #1;
    if (!x.hit) begin
      drive(quiet_ev());
      @(negedge clk);
      chk({tag, "_nohit_busy"}, 32'(busy), 0);
      chk({tag, "_nohit_en"}, 32'(exp_en), 0);
      @(posedge clk); #1;
      return;
    end
    if (!x.exl) begin
      m_last_code = x.code;
      m_last_bd   = x.bd;
    end
    for (int k = 0; k <= stall_n; k++) begin
      drive(junk_ev());
      mem_stall = (k < stall_n);
      @(negedge clk);
      chk({tag, "_c_en"}, 32'(exp_en), 1);
      chk({tag, "_c_flush"}, 32'(flush), 1);
      chk({tag, "_c_busy"}, 32'(busy), 1);
      chk({tag, "_c_rv"}, 32'(redirect_valid), 0);
      chk({tag, "_c_code"}, 32'(exp_code), 32'(x.code));
      chk({tag, "_c_epc"}, exp_epc, x.epc);
      chk({tag, "_c_bd"}, 32'(exp_bd), 32'(x.bd));
      chk({tag, "_c_exl"}, 32'(exl_clean), 32'(x.exl));
      chk({tag, "_c_bvaen"}, 32'(exp_badvaddr_en), 32'(x.bva_en));
      if (x.bva_en) chk({tag, "_c_bva"}, exp_badvaddr, x.bva);
      @(posedge clk); #1;
    end
    for (int f = 0; f < FC; f++) begin
      drive(junk_ev());
      mem_stall = 1'($urandom % 2);
      @(negedge clk);
      chk({tag, "_f_en"}, 32'(exp_en), 0);
      chk({tag, "_f_flush"}, 32'(flush), 1);
      chk({tag, "_f_busy"}, 32'(busy), 1);
      chk({tag, "_f_rv"}, 32'(redirect_valid), 32'(f == FC - 1));
      if (f == FC - 1) chk({tag, "_f_rpc"}, redirect_pc, x.target);
      chk({tag, "_f_code"}, 32'(exp_code), 32'(x.code));
      chk({tag, "_f_epc"}, exp_epc, x.epc);
      @(posedge clk); #1;
    end
    drive(quiet_ev());
    mem_stall = 1'b0;
  endtask

  initial begin
    ev_t e;
    rst = 1'b0;
    mem_stall = 1'b0;
    drive(quiet_ev());
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    e = quiet_ev();
    e.valid = 1'b1; e.sys = 1'b1; e.pc = 32'h8000_1000;
    step("syscall", e, 0);

    e = quiet_ev();
    e.valid = 1'b1; e.eret = 1'b1; e.epc = 32'h8000_1004;
    step("eret", e, 0);

    e = quiet_ev();
    e.valid = 1'b1; e.la = 1'b1; e.bd = 1'b1;
    e.pc = 32'h8000_2004; e.addr = 32'h0000_0003;
    step("ld_adel", e, 3);

    e = quiet_ev();
    e.valid = 1'b1; e.ai = 1'b1; e.irq = 8'h04;
    e.ri = 1'b1; e.ov = 1'b1; e.pc = 32'h8000_3000;
    step("prio_irq", e, 0);
    e.ai = 1'b0;
    step("prio_ri", e, 1);

    e = quiet_ev();
    e.sys = 1'b1;
    step("novalid", e, 0);

    e = quiet_ev();
    e.valid = 1'b1; e.ri = 1'b1; e.bd = 1'b1; e.pc = 32'h0;
    step("wrap", e, 0);

    e = quiet_ev();
    e.valid = 1'b1; e.sys = 1'b1; e.pc = 32'h8000_5000;
    drive(e);
    @(posedge clk); #1;
    drive(quiet_ev());
    mem_stall = 1'b1;
    #2 rst = 1'b0;
    #1 chk_zero("rst_mid");
    m_last_code = 5'd0;
    m_last_bd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rv", 32'(redirect_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    @(posedge clk); #1;

    e = quiet_ev();
    e.valid = 1'b1; e.eret = 1'b1; e.epc = 32'h1234_5678;
    step("eret_cleared", e, 0);

    for (int i = 0; i < 60; i++)
      step("rand", rand_ev(), int'($urandom % 4));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
